pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised successor to the fetch-stage PC next-state logic.
- Owns the PC register, the IF/ID PC pipeline register and a halt state machine.
- Provides PC increment, stall hold, EX-stage branch/jump redirect with IF/ID flush, and halt freeze.
- Sits at the front of the 5-stage pipeline. Outputs feed instruction memory (pc_if) and the ID stage (pc_id, pc_id_inc, id_valid).

Parameters:
- PC_W, 16, PC width in bits.
- INC_BYTES, 2, fetch increment added to PC each advance.
- RESET_VECTOR, 16'h0000, PC value loaded on reset (PC_W bits).
- ALIGN_BITS, 1, number of PC LSBs that must be zero; 0 disables the alignment check.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- stall  input  1  hazard unit load-use stall: hold PC and IF/ID
- halt_req  input  1  HLT instruction decoded in ID this cycle (qualified internally with id_valid)
- redirect  input  1  EX stage resolved taken branch/jump this cycle
- redirect_pc  input  PC_W  target PC for redirect
- pc_if  output  PC_W  current fetch PC (PC register), drives I-mem address
- pc_if_inc  output  PC_W  pc_if + INC_BYTES, combinational
- pc_id  output  PC_W  PC of instruction in ID
- pc_id_inc  output  PC_W  pc_id + INC_BYTES, registered with pc_id
- id_valid  output  1  ID holds a real instruction (0 = bubble)
- halted  output  1  core halted, PC frozen
- misalign  output  1  sticky: a redirect target violated ALIGN_BITS

Behaviour:
- Reset (rst_n=0 at posedge), regardless of other inputs:
  - pc_if = RESET_VECTOR; pc_id = 0; pc_id_inc = 0; id_valid = 0; halted = 0; misalign = 0; FSM = RUN.
- Arithmetic: pc_if_inc = pc_if + INC_BYTES modulo 2^PC_W. Wrap from all-ones is silent; there is no overflow output.
- FSM states:
  - RUN: normal fetch.
  - HALTED: terminal state; only reset exits. halted = (state == HALTED), registered.
- Halt is effective only when halt_req & id_valid.
- RUN, per cycle, priority highest first:
  1. redirect=1: pc_if <= redirect_pc; id_valid <= 0 (flush the wrong-path instruction in IF); pc_id and pc_id_inc hold. Redirect overrides stall and halt_req, because the halt in ID is younger and is squashed.
  2. stall=1: pc_if, pc_id, pc_id_inc and id_valid all hold. halt_req is ignored while stalled and is seen again once stall drops.
  3. effective halt: FSM -> HALTED; pc_if holds the value after the HLT (not incremented again); id_valid <= 0.
  4. otherwise: pc_if <= pc_if_inc; pc_id <= pc_if; pc_id_inc <= pc_if_inc; id_valid <= 1.
- HALTED: all registers hold and every input except rst_n is ignored. Redirect is also ignored, since no older instruction can still be in EX by construction.
- Alignment: when redirect=1 in RUN and redirect_pc[ALIGN_BITS-1:0] != 0, misalign <= 1 (sticky until reset). The redirect still loads redirect_pc unmodified. This check is not generated when ALIGN_BITS=0.
- Latency:
  - One cycle from redirect assertion to target on pc_if.
  - Target reaches pc_id with id_valid=1 on the following non-stalled cycle.
  - One cycle from halt_req to halted=1.
- Reset asserted mid-stall or mid-halt returns to RESET_VECTOR on the next edge; no state survives.

Test Plan:
- Reset then 4 free-run cycles, defaults → pc_if 0000,0002,0004,0006,0008; pc_id lags pc_if by one cycle; id_valid=1 from 2nd edge; pc_id_inc = pc_id+2.
- Stall for 3 cycles at pc_if=0006 → pc_if stays 0006 and pc_id stays 0004; advance resumes to 0008 when stall drops.
- redirect=1, redirect_pc=0040, with stall=1 and halt_req=1 simultaneously → next pc_if=0040, id_valid=0, halted stays 0; the following cycle gives pc_id=0040, id_valid=1.
- halt_req with id_valid at pc_if=000A → halted=1 next edge, pc_if frozen at 000A; a later redirect (0080) is ignored; rst_n=0 → pc_if=0000, halted=0.
- PC_W=16 with pc_if=FFFE, free-run → pc_if=0000 (wrap); redirect_pc=0041 with ALIGN_BITS=1 → pc_if=0041, misalign=1 and still set after further redirects.
- PC_W=32, INC_BYTES=4, RESET_VECTOR=32'h1000, ALIGN_BITS=2 → sequence 1000,1004,1008; redirect 2002 → misalign=1.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage PC register, IF/ID PC pipeline register and halt FSM.
//   clk_i           system clock, all state updates on rising edge
//   rst_n_i         synchronous active-low reset
//   stall_i         load-use stall: hold PC and IF/ID
//   halt_req_i      HLT decoded in ID (qualified with id_valid_o)
//   redirect_i      EX resolved taken branch/jump
//   redirect_pc_i   redirect target
//   pc_if_o         fetch PC, drives I-mem address
//   pc_if_inc_o     pc_if_o + INC_BYTES (combinational)
//   pc_id_o         PC of instruction in ID
//   pc_id_inc_o     pc_id_o + INC_BYTES (registered with pc_id_o)
//   id_valid_o      ID holds a real instruction (0 = bubble)
//   halted_o        core halted, PC frozen
//   misalign_o      sticky: a redirect target violated ALIGN_BITS
module pc_unit #(
    parameter int              PC_W         = 16,
    parameter int              INC_BYTES    = 2,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    parameter int              ALIGN_BITS   = 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            stall_i,
    input  logic            halt_req_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic [PC_W-1:0] pc_if_o,
    output logic [PC_W-1:0] pc_if_inc_o,
    output logic [PC_W-1:0] pc_id_o,
    output logic [PC_W-1:0] pc_id_inc_o,
    output logic            id_valid_o,
    output logic            halted_o,
    output logic            misalign_o
);
    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_id_q, pc_id_d, pc_id_inc_q, pc_id_inc_d;
    logic            valid_q, valid_d, mis_q, mis_d, bad_align, run;

    generate
        if (ALIGN_BITS > 0) begin : g_align
            assign bad_align = |redirect_pc_i[ALIGN_BITS-1:0];
        end else begin : g_noalign
            assign bad_align = 1'b0;
        end
    endgenerate

    assign pc_if_inc_o = pc_q + PC_W'(INC_BYTES);
    assign run         = state_q == S_RUN;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_id_d     = pc_id_q;
        pc_id_inc_d = pc_id_inc_q;
        valid_d     = valid_q;
        mis_d       = mis_q | (run & redirect_i & bad_align);
        if (run) begin
            if (redirect_i) begin
                // Squashes the wrong-path fetch; a stall or halt in ID is younger and dies with it.
                pc_d    = redirect_pc_i;
                valid_d = 1'b0;
            end else if (stall_i) begin
                pc_d = pc_q;
            end else if (halt_req_i && valid_q) begin
                // PC already points past the HLT, so it simply stops advancing.
                state_d = S_HALT;
                valid_d = 1'b0;
            end else begin
                pc_d        = pc_if_inc_o;
                pc_id_d     = pc_q;
                pc_id_inc_d = pc_if_inc_o;
                valid_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_RUN;
            pc_q        <= RESET_VECTOR;
            pc_id_q     <= '0;
            pc_id_inc_q <= '0;
            valid_q     <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_id_q     <= pc_id_d;
            pc_id_inc_q <= pc_id_inc_d;
            valid_q     <= valid_d;
            mis_q       <= mis_d;
        end
    end

    assign pc_if_o     = pc_q;
    assign pc_id_o     = pc_id_q;
    assign pc_id_inc_o = pc_id_inc_q;
    assign id_valid_o  = valid_q;
    assign halted_o    = state_q == S_HALT;
    assign misalign_o  = mis_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed table-driven bench for pc_unit (16-bit default and 32-bit configs).
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        rst_n, stall, halt_req, redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pc_if, pc_if_inc, pc_id, pc_id_inc;
    logic        id_valid, halted, misalign;

    logic        rst_n_b, stall_b, halt_req_b, redirect_b;
    logic [31:0] redirect_pc_b;
    logic [31:0] pc_if_b, pc_if_inc_b, pc_id_b, pc_id_inc_b;
    logic        id_valid_b, halted_b, misalign_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_unit u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .halt_req_i(halt_req),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .pc_if_o(pc_if), .pc_if_inc_o(pc_if_inc), .pc_id_o(pc_id), .pc_id_inc_o(pc_id_inc),
        .id_valid_o(id_valid), .halted_o(halted), .misalign_o(misalign)
    );

    pc_unit #(.PC_W(32), .INC_BYTES(4), .RESET_VECTOR(32'h1000), .ALIGN_BITS(2)) u_dut32 (
        .clk_i(clk), .rst_n_i(rst_n_b), .stall_i(stall_b), .halt_req_i(halt_req_b),
        .redirect_i(redirect_b), .redirect_pc_i(redirect_pc_b),
        .pc_if_o(pc_if_b), .pc_if_inc_o(pc_if_inc_b), .pc_id_o(pc_id_b), .pc_id_inc_o(pc_id_inc_b),
        .id_valid_o(id_valid_b), .halted_o(halted_b), .misalign_o(misalign_b)
    );

    typedef struct {
        logic        rst_n, stall, halt, redir;
        logic [15:0] rpc, pc, id, inc;
        logic        vl, hl, mis;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t v(input logic r, s, h, d, input logic [15:0] rp, p, i, n,
                               input logic vl, hl, m);
        vec_t t;
        t.rst_n = r; t.stall = s; t.halt = h; t.redir = d; t.rpc = rp;
        t.pc = p; t.id = i; t.inc = n; t.vl = vl; t.hl = hl; t.mis = m;
        return t;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic step32(input logic r, s, h, d, input logic [31:0] rp);
        rst_n_b = r; stall_b = s; halt_req_b = h; redirect_b = d; redirect_pc_b = rp;
        @(posedge clk); #1;
    endtask

    initial begin
        //              rst s h d  rpc       pc_if     pc_id     pc_id_inc v h m
        tbl[0]  = v(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        tbl[1]  = v(1, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0002, 1, 0, 0);
        tbl[2]  = v(1, 0, 0, 0, 16'h0000, 16'h0004, 16'h0002, 16'h0004, 1, 0, 0);
        tbl[3]  = v(1, 0, 0, 0, 16'h0000, 16'h0006, 16'h0004, 16'h0006, 1, 0, 0);
        tbl[4]  = v(1, 1, 0, 0, 16'h0000, 16'h0006, 16'h0004, 16'h0006, 1, 0, 0);
        tbl[5]  = v(1, 1, 0, 0, 16'h0000, 16'h0006, 16'h0004, 16'h0006, 1, 0, 0);
        tbl[6]  = v(1, 1, 0, 0, 16'h0000, 16'h0006, 16'h0004, 16'h0006, 1, 0, 0);
        tbl[7]  = v(1, 0, 0, 0, 16'h0000, 16'h0008, 16'h0006, 16'h0008, 1, 0, 0);
        tbl[8]  = v(1, 1, 1, 1, 16'h0040, 16'h0040, 16'h0006, 16'h0008, 0, 0, 0);
        tbl[9]  = v(1, 0, 0, 0, 16'h0000, 16'h0042, 16'h0040, 16'h0042, 1, 0, 0);
        tbl[10] = v(1, 0, 0, 0, 16'h0000, 16'h0044, 16'h0042, 16'h0044, 1, 0, 0);
        tbl[11] = v(1, 1, 1, 0, 16'h0000, 16'h0044, 16'h0042, 16'h0044, 1, 0, 0);
        tbl[12] = v(1, 0, 1, 0, 16'h0000, 16'h0044, 16'h0042, 16'h0044, 0, 1, 0);
        tbl[13] = v(1, 0, 0, 1, 16'h0081, 16'h0044, 16'h0042, 16'h0044, 0, 1, 0);
        tbl[14] = v(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        tbl[15] = v(1, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0002, 1, 0, 0);
        tbl[16] = v(1, 0, 0, 0, 16'h0000, 16'h0004, 16'h0002, 16'h0004, 1, 0, 0);
        tbl[17] = v(1, 0, 0, 0, 16'h0000, 16'h0006, 16'h0004, 16'h0006, 1, 0, 0);
        tbl[18] = v(1, 0, 0, 0, 16'h0000, 16'h0008, 16'h0006, 16'h0008, 1, 0, 0);
        tbl[19] = v(1, 0, 0, 0, 16'h0000, 16'h000A, 16'h0008, 16'h000A, 1, 0, 0);
        tbl[20] = v(1, 0, 1, 0, 16'h0000, 16'h000A, 16'h0008, 16'h000A, 0, 1, 0);
        tbl[21] = v(1, 0, 0, 1, 16'h0081, 16'h000A, 16'h0008, 16'h000A, 0, 1, 0);
        tbl[22] = v(0, 0, 1, 1, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        tbl[23] = v(1, 0, 1, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0002, 1, 0, 0);
        tbl[24] = v(1, 0, 0, 1, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h0002, 0, 0, 0);
        tbl[25] = v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'hFFFE, 16'h0000, 1, 0, 0);
        tbl[26] = v(1, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0002, 1, 0, 0);
        tbl[27] = v(1, 0, 0, 1, 16'h0041, 16'h0041, 16'h0000, 16'h0002, 0, 0, 1);
        tbl[28] = v(1, 0, 0, 1, 16'h0100, 16'h0100, 16'h0000, 16'h0002, 0, 0, 1);
        tbl[29] = v(1, 0, 0, 0, 16'h0000, 16'h0102, 16'h0100, 16'h0102, 1, 0, 1);
        tbl[30] = v(1, 1, 0, 1, 16'h0044, 16'h0044, 16'h0100, 16'h0102, 0, 0, 1);
        tbl[31] = v(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);

        rst_n_b = 0; stall_b = 0; halt_req_b = 0; redirect_b = 0; redirect_pc_b = '0;
        #1;
        for (int i = 0; i < 32; i++) begin
            rst_n = tbl[i].rst_n; stall = tbl[i].stall; halt_req = tbl[i].halt;
            redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
            @(posedge clk); #1;
            chk("pc_if",     i, {16'h0, pc_if},     {16'h0, tbl[i].pc});
            chk("pc_if_inc", i, {16'h0, pc_if_inc}, {16'h0, tbl[i].pc + 16'd2});
            chk("pc_id",     i, {16'h0, pc_id},     {16'h0, tbl[i].id});
            chk("pc_id_inc", i, {16'h0, pc_id_inc}, {16'h0, tbl[i].inc});
            chk("id_valid",  i, {31'h0, id_valid},  {31'h0, tbl[i].vl});
            chk("halted",    i, {31'h0, halted},    {31'h0, tbl[i].hl});
            chk("misalign",  i, {31'h0, misalign},  {31'h0, tbl[i].mis});
        end

        // 32-bit, INC_BYTES=4, RESET_VECTOR=1000, ALIGN_BITS=2
        step32(0, 0, 0, 0, 32'h0);
        chk("w32 rst pc_if", 100, pc_if_b, 32'h1000);
        chk("w32 rst valid", 100, {31'h0, id_valid_b}, 32'h0);
        step32(1, 0, 0, 0, 32'h0);
        chk("w32 pc_if", 101, pc_if_b, 32'h1004);
        chk("w32 pc_if_inc", 101, pc_if_inc_b, 32'h1008);
        step32(1, 0, 0, 0, 32'h0);
        chk("w32 pc_if", 102, pc_if_b, 32'h1008);
        chk("w32 pc_id", 102, pc_id_b, 32'h1004);
        chk("w32 pc_id_inc", 102, pc_id_inc_b, 32'h1008);
        step32(1, 0, 0, 1, 32'h2002);
        chk("w32 redirect pc_if", 103, pc_if_b, 32'h2002);
        chk("w32 misalign", 103, {31'h0, misalign_b}, 32'h1);
        chk("w32 flush valid", 103, {31'h0, id_valid_b}, 32'h0);
        step32(1, 0, 0, 0, 32'h0);
        chk("w32 pc_if", 104, pc_if_b, 32'h2006);
        chk("w32 pc_id", 104, pc_id_b, 32'h2002);
        chk("w32 valid", 104, {31'h0, id_valid_b}, 32'h1);
        chk("w32 misalign sticky", 104, {31'h0, misalign_b}, 32'h1);
        step32(1, 0, 0, 1, 32'h3000);
        chk("w32 aligned redirect", 105, pc_if_b, 32'h3000);
        chk("w32 misalign sticky2", 105, {31'h0, misalign_b}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
